// File: rtl/sram_like_mem_slave.sv
// sram_like_mem_slave: word-organised, byte-writable memory responder for the
// sram-like data interface. It holds one outstanding transaction and answers
// after a fixed, parameterised latency.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | ready; data_addr_ok follows data_req, request latched on accept
//  WAIT  | latency countdown; master inputs ignored
//  RESP  | data_data_ok high; write committed at end of cycle, rdata valid
module sram_like_mem_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    wr_q;
    logic [1:0]              size_q;
    logic [1:0]              lane_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [31:0]             mem [DEPTH];

    logic                    accept;
    logic                    rd_load;
    logic [ADDR_WIDTH-1:0]   rd_idx;
    logic [3:0]              byte_mask;

    // Address bits above the word index alias onto the same memory.
    logic                    unused_addr_hi;
    assign unused_addr_hi = ^data_addr[31:ADDR_WIDTH+2];

    // Handshake outputs: accept only when idle and out of reset; the response
    // pulse is tied to RESP and is suppressed while reset is asserted.
    assign data_addr_ok = resetn && (state == IDLE) && data_req;
    assign accept       = data_addr_ok;
    assign data_data_ok = resetn && (state == RESP);

    // Pick the word to load into rdata on the edge entering RESP. With
    // LATENCY=1 that edge is the accept edge, so the live address is used.
    always_comb begin
        rd_load = 1'b0;
        rd_idx  = idx_q;
        if (state == IDLE) begin
            rd_idx  = data_addr[ADDR_WIDTH+1:2];
            rd_load = accept && !data_wr && (LATENCY == 1);
        end else if (state == WAIT) begin
            rd_load = (cnt == 4'd1) && !wr_q;
        end
    end

    // Byte-lane enables from the latched size and low address bits.
    always_comb begin
        case (size_q)
            2'b00:   byte_mask = 4'b0001 << lane_q;
            2'b01:   byte_mask = lane_q[1] ? 4'b1100 : 4'b0011;
            default: byte_mask = 4'b1111;
        endcase
    end

    // Transaction sequencer: IDLE -> (WAIT countdown) -> RESP -> IDLE.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt   <= 4'(LATENCY - 1);
                        state <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        cnt   <= '0;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the request on acceptance; nothing else updates these.
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= data_wr;
            size_q  <= data_size;
            lane_q  <= data_addr[1:0];
            idx_q   <= data_addr[ADDR_WIDTH+1:2];
            wdata_q <= data_wdata;
        end
    end

    // Registered read data: loaded for reads only, holds otherwise.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_rdata <= '0;
        end else if (rd_load) begin
            data_rdata <= mem[rd_idx];
        end
    end

    // Masked write at the edge ending RESP; a reset in that cycle drops it.
    always_ff @(posedge clk) begin
        if (resetn && (state == RESP) && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_mask[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_like_mem_slave.sv
// Bench for sram_like_mem_slave: two instances (LATENCY=2 and LATENCY=1)
// driven by directed and random transactions against a byte-level model.
module tb_sram_like_mem_slave;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req [2];
    logic        wr [2];
    logic [1:0]  size [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        addr_ok [2];
    logic        data_ok [2];

    int          nvec = 0;
    int          nerr = 0;
    int          cyc = 0;

    logic [31:0] mdl [2][4096];
    logic [3:0]  vld [2][4096];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_like_mem_slave #(.ADDR_WIDTH(12), .LATENCY(2)) dut0 (
        .clk(clk), .resetn(resetn), .data_req(req[0]), .data_wr(wr[0]),
        .data_size(size[0]), .data_addr(addr[0]), .data_wdata(wdata[0]),
        .data_rdata(rdata[0]), .data_addr_ok(addr_ok[0]), .data_data_ok(data_ok[0])
    );

    sram_like_mem_slave #(.ADDR_WIDTH(12), .LATENCY(1)) dut1 (
        .clk(clk), .resetn(resetn), .data_req(req[1]), .data_wr(wr[1]),
        .data_size(size[1]), .data_addr(addr[1]), .data_wdata(wdata[1]),
        .data_rdata(rdata[1]), .data_addr_ok(addr_ok[1]), .data_data_ok(data_ok[1])
    );

    function automatic int lat_of(input int b);
        return (b == 0) ? 2 : 1;
    endfunction

    // Lanes touched by an access, straight from the size/offset rules.
    function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [1:0] off);
        int first;
        int count;
        logic [3:0] m;
        if (sz == 2'b00) begin
            first = int'(off);
            count = 1;
        end else if (sz == 2'b01) begin
            first = off[1] ? 2 : 0;
            count = 2;
        end else begin
            first = 0;
            count = 4;
        end
        m = '0;
        for (int i = 0; i < 4; i++) m[i] = (i >= first) && (i < first + count);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction on instance b; optionally churns inputs while busy.
    task automatic txn(input int b, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input bit churn,
                       output logic [31:0] rd, output int okc);
        int          n;
        logic        dok;
        logic        aok;
        logic [11:0] ix;
        logic [3:0]  m;
        logic [31:0] vm;
        @(posedge clk); #1;
        req[b] = 1'b1; wr[b] = w; size[b] = sz; addr[b] = a; wdata[b] = wd;
        #1;
        chk("accept", 32'(addr_ok[b]), 32'd1);
        ix = a[13:2];
        m  = lanes(sz, a[1:0]);
        n = 0; dok = 1'b0; aok = 1'b0;
        while (!dok && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (churn) begin
                req[b]   = 1'($urandom);
                wr[b]    = 1'($urandom);
                size[b]  = 2'($urandom);
                addr[b]  = $urandom & 32'h0000_003F;
                wdata[b] = $urandom;
            end else begin
                req[b] = 1'b0;
            end
            #1;
            dok = data_ok[b];
            aok = addr_ok[b];
            if (!dok) chk("busy_addr_ok", 32'(aok), 32'd0);
        end
        req[b] = 1'b0;
        chk("latency", 32'(n), 32'(lat_of(b)));
        chk("ok_overlap", 32'(aok), 32'd0);
        rd  = rdata[b];
        okc = cyc;
        if (!w) begin
            for (int i = 0; i < 4; i++) vm[8*i +: 8] = {8{vld[b][ix][i]}};
            chk("rdata", rd & vm, mdl[b][ix] & vm);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m[i]) begin
                    mdl[b][ix][8*i +: 8] = wd[8*i +: 8];
                    vld[b][ix][i] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          okc;
        int          prev;
        for (int b = 0; b < 2; b++) begin
            req[b] = 1'b0; wr[b] = 1'b0; size[b] = 2'b10; addr[b] = '0; wdata[b] = '0;
            for (int i = 0; i < 4096; i++) begin
                mdl[b][i] = '0;
                vld[b][i] = '0;
            end
        end

        // Reset: outputs quiet, addr_ok gated even with a request pending.
        resetn = 1'b0;
        req[0] = 1'b1;
        req[1] = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_addr_ok0", 32'(addr_ok[0]), 32'd0);
        chk("rst_addr_ok1", 32'(addr_ok[1]), 32'd0);
        chk("rst_data_ok0", 32'(data_ok[0]), 32'd0);
        chk("rst_rdata0", rdata[0], 32'd0);
        chk("rst_rdata1", rdata[1], 32'd0);
        req[0] = 1'b0;
        req[1] = 1'b0;
        resetn = 1'b1;

        // Read latency at LATENCY=2, then immediate re-accept.
        txn(0, 1'b1, 2'b10, 32'h14, 32'hDEADBEEF, 1'b0, rd, okc);
        txn(0, 1'b0, 2'b10, 32'h14, 32'h0, 1'b0, rd, okc);
        chk("tp_read", rd, 32'hDEADBEEF);
        prev = okc;
        txn(0, 1'b0, 2'b10, 32'h14, 32'h0, 1'b0, rd, okc);
        chk("tp_reaccept_gap", 32'(okc - prev), 32'd3);

        // Byte and halfword writes.
        txn(0, 1'b1, 2'b10, 32'h0, 32'h11223344, 1'b0, rd, okc);
        txn(0, 1'b1, 2'b00, 32'h2, 32'h00AA0000, 1'b0, rd, okc);
        txn(0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, rd, okc);
        chk("tp_sb", rd, 32'h11AA3344);
        txn(0, 1'b1, 2'b01, 32'h1, 32'h0000BBCC, 1'b0, rd, okc);
        txn(0, 1'b0, 2'b01, 32'h2, 32'h0, 1'b0, rd, okc);
        chk("tp_sh", rd, 32'h11AABBCC);
        txn(0, 1'b1, 2'b10, 32'h3, 32'h0, 1'b0, rd, okc);
        txn(0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0, rd, okc);
        chk("tp_sw", rd, 32'h00000000);

        // LATENCY=1 back-to-back alternating write/read.
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            txn(1, (i % 2 == 0), 2'b10, 32'h40, 32'h12345678, 1'b0, rd, okc);
            if (i % 2 == 1) chk("b2b_read", rd, 32'h12345678);
            if (i > 0) chk("b2b_gap", 32'(okc - prev), 32'd2);
            prev = okc;
        end

        // Input churn during WAIT must not disturb the transaction.
        txn(0, 1'b1, 2'b10, 32'h8, 32'h0BADCAFE, 1'b0, rd, okc);
        txn(0, 1'b0, 2'b10, 32'h8, 32'h0, 1'b1, rd, okc);
        chk("churn_read", rd, 32'h0BADCAFE);
        for (int i = 0; i < 16; i++) txn(0, 1'b0, 2'b10, 32'(i * 4), 32'h0, 1'b0, rd, okc);

        // Reset in the RESP cycle of a write drops it.
        txn(0, 1'b1, 2'b10, 32'h10, 32'h01020304, 1'b0, rd, okc);
        txn(0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, rd, okc);
        chk("pre_rst_read", rd, 32'h01020304);
        @(posedge clk); #1;
        req[0] = 1'b1; wr[0] = 1'b1; size[0] = 2'b10; addr[0] = 32'h10; wdata[0] = 32'hCAFEF00D;
        #1;
        chk("rst_wr_accept", 32'(addr_ok[0]), 32'd1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        #1;
        chk("rst_wr_wait", 32'(data_ok[0]), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("rst_wr_resp_ok", 32'(data_ok[0]), 32'd0);
        @(posedge clk); #1;
        chk("rst_wr_after_ok", 32'(data_ok[0]), 32'd0);
        chk("rst_wr_rdata", rdata[0], 32'd0);
        resetn = 1'b1;
        txn(0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, rd, okc);
        chk("rst_wr_old", rd, 32'h01020304);

        // Aliasing of address bits above the word index.
        txn(0, 1'b1, 2'b10, 32'h00004004, 32'h5A5A5A5A, 1'b0, rd, okc);
        txn(0, 1'b0, 2'b10, 32'h00000004, 32'h0, 1'b0, rd, okc);
        chk("alias", rd, 32'h5A5A5A5A);

        // Random traffic on both instances against the model.
        for (int i = 0; i < 200; i++) begin
            int          b;
            logic [31:0] a;
            b = int'($urandom_range(0, 1));
            a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
            txn(b, 1'($urandom), 2'($urandom), a, $urandom, 1'($urandom), rd, okc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
